mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_rr_arb2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared cache definitions for the memory port arbiter:
//               arbiter state encoding, default address/line widths and
//               the encoding of the round-robin history bit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Default line address width and cache line width.
  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 128;

  // Arbiter states.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ICACHE = 2'd1,
    ARB_DCACHE = 2'd2,
    ARB_KILL   = 2'd3
  } type_arb_states_e;

  // Round-robin history: which requester received the most recent grant.
  localparam logic GRANT_ICACHE = 1'b0;
  localparam logic GRANT_DCACHE = 1'b1;

  // Bit positions of the requesters in the two-bit req/grant vectors.
  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin pick. A lone request is granted as-is;
//               on a tie the requester that did NOT win last time is chosen.
// Ports       : req[1:0]   - request vector (bit 0 icache, bit 1 dcache)
//               last_grant - requester granted most recently
//               grant[1:0] - one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == GRANT_DCACHE) ? 2'b01 : 2'b10;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single memory port between the icache (line
//               refills) and the dcache (allocates and writebacks).
//               One transaction owns the port at a time; ties are broken
//               round-robin. A requester may abort its own transaction
//               with kill, which is forwarded to memory, followed by a
//               one-cycle ARB_KILL quiet period.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               icache2arb_req/addr/kill_i - icache refill request
//               arb2icache_ack_o           - icache refill data valid
//               dcache2arb_req/wr/addr/wdata/kill_i - dcache request
//               arb2dcache_ack_o           - dcache transaction complete
//               arb2mem_req/wr/addr/wdata/kill_o - shared memory port
//               mem2arb_ack_i, mem2arb_rdata_i   - memory completion/data
//               arb2icache_rdata_o, arb2dcache_rdata_o - read line fan-out
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // icache
  input  logic              icache2arb_req_i,
  input  logic [ADDR_W-1:0] icache2arb_addr_i,
  input  logic              icache2arb_kill_i,
  output logic              arb2icache_ack_o,
  output logic [LINE_W-1:0] arb2icache_rdata_o,
  // dcache
  input  logic              dcache2arb_req_i,
  input  logic              dcache2arb_wr_i,
  input  logic [ADDR_W-1:0] dcache2arb_addr_i,
  input  logic [LINE_W-1:0] dcache2arb_wdata_i,
  input  logic              dcache2arb_kill_i,
  output logic              arb2dcache_ack_o,
  output logic [LINE_W-1:0] arb2dcache_rdata_o,
  // memory
  output logic              arb2mem_req_o,
  output logic              arb2mem_wr_o,
  output logic [ADDR_W-1:0] arb2mem_addr_o,
  output logic [LINE_W-1:0] arb2mem_wdata_o,
  output logic              arb2mem_kill_o,
  input  logic              mem2arb_ack_i,
  input  logic [LINE_W-1:0] mem2arb_rdata_i
);

  type_arb_states_e state_q, state_d;
  // Round-robin history (last_grant_ff): who was granted most recently.
  logic             last_grant_q, last_grant_d;

  logic [1:0]       req_eff;
  logic [1:0]       grant;

  // A requester killing in the same idle cycle is not eligible for a grant.
  assign req_eff[REQ_ICACHE] = icache2arb_req_i & ~icache2arb_kill_i;
  assign req_eff[REQ_DCACHE] = dcache2arb_req_i & ~dcache2arb_kill_i;

  rr_arb2 u_rr_arb2 (
    .req        (req_eff),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // The read line is not owned by the arbiter; both caches see it as-is
  // and qualify it with their own ack.
  assign arb2icache_rdata_o = mem2arb_rdata_i;
  assign arb2dcache_rdata_o = mem2arb_rdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_DCACHE;  // icache wins the first tie
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state and outputs. Every output is a function of the registered
  // state, so an asynchronous reset forces ARB_IDLE and therefore all-zero
  // outputs immediately.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    arb2mem_req_o    = 1'b0;
    arb2mem_wr_o     = 1'b0;
    arb2mem_addr_o   = '0;
    arb2mem_wdata_o  = '0;
    arb2mem_kill_o   = 1'b0;
    arb2icache_ack_o = 1'b0;
    arb2dcache_ack_o = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant[REQ_ICACHE]) begin
          state_d      = ARB_ICACHE;
          last_grant_d = GRANT_ICACHE;
        end else if (grant[REQ_DCACHE]) begin
          state_d      = ARB_DCACHE;
          last_grant_d = GRANT_DCACHE;
        end
      end

      ARB_ICACHE: begin
        arb2mem_addr_o = icache2arb_addr_i;
        // Kill takes priority over a coincident memory ack.
        if (icache2arb_kill_i) begin
          arb2mem_kill_o = 1'b1;
          state_d        = ARB_KILL;
        end else begin
          arb2mem_req_o    = icache2arb_req_i;
          arb2icache_ack_o = mem2arb_ack_i;
          if (mem2arb_ack_i) begin
            state_d = ARB_IDLE;
          end
        end
      end

      ARB_DCACHE: begin
        arb2mem_wr_o    = dcache2arb_wr_i;
        arb2mem_addr_o  = dcache2arb_addr_i;
        arb2mem_wdata_o = dcache2arb_wdata_i;
        if (dcache2arb_kill_i) begin
          arb2mem_kill_o = 1'b1;
          state_d        = ARB_KILL;
        end else begin
          arb2mem_req_o    = dcache2arb_req_i;
          arb2dcache_ack_o = mem2arb_ack_i;
          if (mem2arb_ack_i) begin
            state_d = ARB_IDLE;
          end
        end
      end

      // Quiet cycle after a kill: a late memory ack belongs to the aborted
      // transaction and is dropped.
      ARB_KILL: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//               followed by randomized cache/memory traffic. A behavioural
//               ownership model predicts every cycle's port outputs and the
//               order of completed transactions; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  // Port owner as seen by the model.
  localparam int OWN_NONE   = 0;
  localparam int OWN_ICACHE = 1;
  localparam int OWN_DCACHE = 2;
  localparam int OWN_QUIET  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          icache2arb_req_i, icache2arb_kill_i;
  logic [AW-1:0] icache2arb_addr_i;
  logic          arb2icache_ack_o;
  logic [LW-1:0] arb2icache_rdata_o;
  logic          dcache2arb_req_i, dcache2arb_wr_i, dcache2arb_kill_i;
  logic [AW-1:0] dcache2arb_addr_i;
  logic [LW-1:0] dcache2arb_wdata_i;
  logic          arb2dcache_ack_o;
  logic [LW-1:0] arb2dcache_rdata_o;
  logic          arb2mem_req_o, arb2mem_wr_o, arb2mem_kill_o;
  logic [AW-1:0] arb2mem_addr_o;
  logic [LW-1:0] arb2mem_wdata_o;
  logic          mem2arb_ack_i;
  logic [LW-1:0] mem2arb_rdata_i;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .icache2arb_req_i   (icache2arb_req_i),
    .icache2arb_addr_i  (icache2arb_addr_i),
    .icache2arb_kill_i  (icache2arb_kill_i),
    .arb2icache_ack_o   (arb2icache_ack_o),
    .arb2icache_rdata_o (arb2icache_rdata_o),
    .dcache2arb_req_i   (dcache2arb_req_i),
    .dcache2arb_wr_i    (dcache2arb_wr_i),
    .dcache2arb_addr_i  (dcache2arb_addr_i),
    .dcache2arb_wdata_i (dcache2arb_wdata_i),
    .dcache2arb_kill_i  (dcache2arb_kill_i),
    .arb2dcache_ack_o   (arb2dcache_ack_o),
    .arb2dcache_rdata_o (arb2dcache_rdata_o),
    .arb2mem_req_o      (arb2mem_req_o),
    .arb2mem_wr_o       (arb2mem_wr_o),
    .arb2mem_addr_o     (arb2mem_addr_o),
    .arb2mem_wdata_o    (arb2mem_wdata_o),
    .arb2mem_kill_o     (arb2mem_kill_o),
    .mem2arb_ack_i      (mem2arb_ack_i),
    .mem2arb_rdata_i    (mem2arb_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req;
    logic          wr;
    logic          kill;
    logic          iack;
    logic          dack;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];   // expected port outputs, one entry per checked cycle
  int   ack_q[$];   // expected completion order (OWN_ICACHE / OWN_DCACHE)
  exp_t last_e;

  int nchecks = 0;
  int nerrors = 0;
  int cyc     = 0;

  // Reference model state.
  int owner;
  bit icache_next_on_tie;

  task automatic chk(input string name, input int c,
                     input logic [LW-1:0] got, input logic [LW-1:0] want);
    nchecks++;
    if (got !== want) begin
      nerrors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, c, got, want);
    end
  endtask

  task automatic model_reset();
    owner              = OWN_NONE;
    icache_next_on_tie = 1'b1;
  endtask

  // What the port must show this cycle, given who owns it and the inputs.
  function automatic exp_t model_outputs();
    exp_t e;
    e.req = 0; e.wr = 0; e.kill = 0; e.iack = 0; e.dack = 0;
    e.addr = '0; e.wdata = '0; e.rdata = mem2arb_rdata_i; e.cyc = cyc;
    if (owner == OWN_ICACHE) begin
      e.addr = icache2arb_addr_i;
      e.kill = icache2arb_kill_i;
      e.req  = icache2arb_req_i & ~icache2arb_kill_i;
      e.iack = mem2arb_ack_i & ~icache2arb_kill_i;
    end else if (owner == OWN_DCACHE) begin
      e.addr  = dcache2arb_addr_i;
      e.wr    = dcache2arb_wr_i;
      e.wdata = dcache2arb_wdata_i;
      e.kill  = dcache2arb_kill_i;
      e.req   = dcache2arb_req_i & ~dcache2arb_kill_i;
      e.dack  = mem2arb_ack_i & ~dcache2arb_kill_i;
    end
    return e;
  endfunction

  // Ownership change at the clock edge.
  task automatic model_advance(input exp_t e);
    bit wants_i, wants_d;
    case (owner)
      OWN_NONE: begin
        wants_i = icache2arb_req_i & ~icache2arb_kill_i;
        wants_d = dcache2arb_req_i & ~dcache2arb_kill_i;
        if (wants_i && wants_d) owner = icache_next_on_tie ? OWN_ICACHE : OWN_DCACHE;
        else if (wants_i)       owner = OWN_ICACHE;
        else if (wants_d)       owner = OWN_DCACHE;
        if (owner == OWN_ICACHE) icache_next_on_tie = 1'b0;
        if (owner == OWN_DCACHE) icache_next_on_tie = 1'b1;
      end
      OWN_ICACHE, OWN_DCACHE: begin
        if (e.kill)                 owner = OWN_QUIET;
        else if (e.iack || e.dack)  owner = OWN_NONE;
      end
      default: owner = OWN_NONE;
    endcase
  endtask

  // One clock cycle: inputs are already applied; predict, then advance.
  task automatic step();
    exp_t e;
    e = model_outputs();
    exp_q.push_back(e);
    if (e.iack) ack_q.push_back(OWN_ICACHE);
    if (e.dack) ack_q.push_back(OWN_DCACHE);
    last_e = e;
    @(posedge clk);
    model_advance(e);
    cyc++;
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    int   got, want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_req",      e.cyc, LW'(arb2mem_req_o),    LW'(e.req));
        chk("mem_wr",       e.cyc, LW'(arb2mem_wr_o),     LW'(e.wr));
        chk("mem_kill",     e.cyc, LW'(arb2mem_kill_o),   LW'(e.kill));
        chk("mem_addr",     e.cyc, LW'(arb2mem_addr_o),   LW'(e.addr));
        chk("mem_wdata",    e.cyc, arb2mem_wdata_o,       e.wdata);
        chk("icache_ack",   e.cyc, LW'(arb2icache_ack_o), LW'(e.iack));
        chk("dcache_ack",   e.cyc, LW'(arb2dcache_ack_o), LW'(e.dack));
        chk("icache_rdata", e.cyc, arb2icache_rdata_o,    e.rdata);
        chk("dcache_rdata", e.cyc, arb2dcache_rdata_o,    e.rdata);
      end
      if (arb2icache_ack_o || arb2dcache_ack_o) begin
        got = (arb2icache_ack_o && arb2dcache_ack_o) ? 3 :
              (arb2icache_ack_o ? OWN_ICACHE : OWN_DCACHE);
        want = (ack_q.size() > 0) ? ack_q.pop_front() : OWN_NONE;
        chk("ack_order", cyc, LW'(got), LW'(want));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   cyc, LW'(arb2mem_req_o),    '0);
    chk({tag, "_wr"},    cyc, LW'(arb2mem_wr_o),     '0);
    chk({tag, "_kill"},  cyc, LW'(arb2mem_kill_o),   '0);
    chk({tag, "_addr"},  cyc, LW'(arb2mem_addr_o),   '0);
    chk({tag, "_wdata"}, cyc, arb2mem_wdata_o,       '0);
    chk({tag, "_iack"},  cyc, LW'(arb2icache_ack_o), '0);
    chk({tag, "_dack"},  cyc, LW'(arb2dcache_ack_o), '0);
  endtask

  task automatic idle_inputs();
    icache2arb_req_i = 0; icache2arb_kill_i = 0; icache2arb_addr_i = '0;
    dcache2arb_req_i = 0; dcache2arb_kill_i = 0; dcache2arb_wr_i = 0;
    dcache2arb_addr_i = '0; dcache2arb_wdata_i = '0;
    mem2arb_ack_i = 0; mem2arb_rdata_i = '0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  bit ipend, dpend;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Tie right after reset goes to icache, then grants alternate.
    icache2arb_req_i = 1; icache2arb_addr_i = 32'h0000_1000;
    dcache2arb_req_i = 1; dcache2arb_addr_i = 32'h0000_2000;
    dcache2arb_wr_i = 1; dcache2arb_wdata_i = rand_line();
    for (int t = 0; t < 3; t++) begin
      step();                       // arbitration cycle
      step();                       // granted, no ack yet
      mem2arb_ack_i = 1; mem2arb_rdata_i = rand_line();
      step();                       // completion
      mem2arb_ack_i = 0;
      icache2arb_addr_i = icache2arb_addr_i + 32'h40;
      dcache2arb_addr_i = dcache2arb_addr_i + 32'h40;
    end
    idle_inputs();
    step();

    // dcache writeback held for 5 granted cycles, ack on the fifth.
    dcache2arb_req_i = 1; dcache2arb_wr_i = 1;
    dcache2arb_addr_i = 32'h8000_0040; dcache2arb_wdata_i = {16{8'hA5}};
    step();
    repeat (4) step();
    mem2arb_ack_i = 1;
    step();
    idle_inputs();
    step();

    // dcache kill in the third granted cycle; ack during ARB_KILL dropped.
    dcache2arb_req_i = 1; dcache2arb_addr_i = 32'h0000_3000;
    step();
    step(); step();
    dcache2arb_kill_i = 1;
    step();
    idle_inputs(); mem2arb_ack_i = 1;
    step();
    idle_inputs();
    step();

    // icache kill coinciding with ack; dcache kill while not granted.
    icache2arb_req_i = 1; icache2arb_addr_i = 32'h0000_4000;
    step();
    dcache2arb_req_i = 1; dcache2arb_kill_i = 1;
    step();
    dcache2arb_req_i = 0; dcache2arb_kill_i = 0;
    icache2arb_kill_i = 1; mem2arb_ack_i = 1;
    step();
    idle_inputs();
    step();

    // Kill in idle suppresses that requester's grant.
    icache2arb_req_i = 1; icache2arb_kill_i = 1;
    step();
    idle_inputs();
    step(); step();

    // Asynchronous reset while a refill is pending.
    icache2arb_req_i = 1; icache2arb_addr_i = 32'h0000_5000;
    step(); step();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 chk_all_zero("in_rst");
    rst_n = 1'b1;
    step();                         // back in ARB_IDLE: nothing on the port
    step();
    mem2arb_ack_i = 1;
    step();
    idle_inputs();
    step();

    // Randomized traffic.
    ipend = 0; dpend = 0;
    for (int n = 0; n < 3000; n++) begin
      if (icache2arb_kill_i) begin
        icache2arb_kill_i = 0; icache2arb_req_i = 0; ipend = 0;
      end else if (ipend && last_e.iack) begin
        icache2arb_req_i = 0; ipend = 0;
      end
      if (dcache2arb_kill_i) begin
        dcache2arb_kill_i = 0; dcache2arb_req_i = 0; dpend = 0;
      end else if (dpend && last_e.dack) begin
        dcache2arb_req_i = 0; dpend = 0;
      end
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1; icache2arb_req_i = 1; icache2arb_addr_i = $urandom();
      end else if (ipend && $urandom_range(0, 15) == 0) begin
        icache2arb_kill_i = 1;
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1; dcache2arb_req_i = 1; dcache2arb_addr_i = $urandom();
        dcache2arb_wr_i = 1'($urandom_range(0, 1));
        dcache2arb_wdata_i = rand_line();
      end else if (dpend && $urandom_range(0, 15) == 0) begin
        dcache2arb_kill_i = 1;
      end
      mem2arb_ack_i   = ($urandom_range(0, 3) == 0);
      mem2arb_rdata_i = rand_line();
      step();
    end

    idle_inputs();
    step(); step();
    @(negedge clk);
    #1;
    chk("exp_queue_drained", cyc, LW'(exp_q.size()), '0);
    chk("ack_queue_drained", cyc, LW'(ack_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
